// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   - 4-bit opcode map (OP_MOVB .. OP_MUL)
//   - CCR / flag bit positions, packed as {V,C,N,Z}
//   - FSM state encoding used by alu_pipe when the multiplier (ALU_MUL_EN) is built
package alu_pkg;

    localparam logic [3:0] OP_MOVB = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_RLC  = 4'b0101;
    localparam logic [3:0] OP_RRC  = 4'b0110;
    localparam logic [3:0] OP_SETC = 4'b0111;
    localparam logic [3:0] OP_CLRC = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_NEG  = 4'b1010;
    localparam logic [3:0] OP_INCB = 4'b1011;
    localparam logic [3:0] OP_DECB = 4'b1100;
    localparam logic [3:0] OP_DECA = 4'b1101;
    localparam logic [3:0] OP_MOVA = 4'b1110;
    localparam logic [3:0] OP_MUL  = 4'b1111;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;
    localparam int CCR_V = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational single-cycle ALU datapath.
// Ports:
//   A, B       in   WIDTH  operands
//   opcode     in   4      operation select (see alu_pkg)
//   ccr_in     in   4      current CCR {V,C,N,Z}; supplies carry-in and untouched flags
//   res        out  WIDTH  result
//   flags_nxt  out  4      {V,C,N,Z} to be registered with the result
// Opcode 1111 is reported as the undefined op (res=0, flags=0); when the
// multiplier is built the pipe takes that opcode down its own path instead.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    input  logic [3:0]       ccr_in,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags_nxt
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

    logic [WIDTH:0] sum;
    logic           upd_zn;

    always_comb begin
        res       = '0;
        flags_nxt = ccr_in;
        sum       = '0;
        upd_zn    = 1'b0;
        case (opcode)
            OP_MOVB: res = B;
            OP_ADD: begin
                sum = {1'b0, A} + {1'b0, B};
                res = sum[WIDTH-1:0];
                flags_nxt[CCR_C] = sum[WIDTH];
                flags_nxt[CCR_V] = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
                upd_zn = 1'b1;
            end
            OP_SUB: begin
                // bit WIDTH of the extended difference is the borrow
                sum = {1'b0, A} - {1'b0, B};
                res = sum[WIDTH-1:0];
                flags_nxt[CCR_C] = sum[WIDTH];
                flags_nxt[CCR_V] = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
                upd_zn = 1'b1;
            end
            OP_AND: begin
                res    = A & B;
                upd_zn = 1'b1;
            end
            OP_OR: begin
                res    = A | B;
                upd_zn = 1'b1;
            end
            OP_RLC: begin
                res = {B[WIDTH-2:0], ccr_in[CCR_C]};
                flags_nxt[CCR_C] = B[WIDTH-1];
                flags_nxt[CCR_V] = B[WIDTH-2] ^ B[WIDTH-1];
            end
            OP_RRC: begin
                res = {ccr_in[CCR_C], B[WIDTH-1:1]};
                flags_nxt[CCR_C] = B[0];
                flags_nxt[CCR_V] = ccr_in[CCR_C] ^ B[WIDTH-1];
            end
            OP_SETC: flags_nxt[CCR_C] = 1'b1;
            OP_CLRC: flags_nxt[CCR_C] = 1'b0;
            OP_NOT: begin
                res    = ~B;
                upd_zn = 1'b1;
            end
            OP_NEG: begin
                res = ~B + WIDTH'(1);
                flags_nxt[CCR_V] = (B == MIN_NEG);
                upd_zn = 1'b1;
            end
            OP_INCB: begin
                sum = {1'b0, B} + ONE_X;
                res = sum[WIDTH-1:0];
                flags_nxt[CCR_C] = sum[WIDTH];
                flags_nxt[CCR_V] = !B[WIDTH-1] && sum[WIDTH-1];
                upd_zn = 1'b1;
            end
            OP_DECB: begin
                sum = {1'b0, B} - ONE_X;
                res = sum[WIDTH-1:0];
                flags_nxt[CCR_C] = sum[WIDTH];
                flags_nxt[CCR_V] = B[WIDTH-1] && !sum[WIDTH-1];
                upd_zn = 1'b1;
            end
            OP_DECA: begin
                sum = {1'b0, A} - ONE_X;
                res = sum[WIDTH-1:0];
                flags_nxt[CCR_C] = sum[WIDTH];
                flags_nxt[CCR_V] = A[WIDTH-1] && !sum[WIDTH-1];
                upd_zn = 1'b1;
            end
            OP_MOVA: res = A;
            default: begin
                res       = '0;
                flags_nxt = '0;
            end
        endcase
        if (upd_zn) begin
            flags_nxt[CCR_Z] = (res == '0);
            flags_nxt[CCR_N] = res[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-bit ALU with one registered result stage, valid/ready
// handshakes on both sides and a live Condition Code Register.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  op issue handshake
//   A, B, opcode         operands and operation select
//   out_valid/out_ready  result retire handshake
//   out, flags           registered result and the {V,C,N,Z} produced with it
//   ccr                  live CCR {V,C,N,Z}
// Build option: define ALU_MUL_EN to make opcode 1111 an unsigned shift-add
// multiply taking WIDTH cycles; otherwise 1111 is the undefined op.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | accepting ops (subject to the output register being free)
// ST_MUL_RUN | multiply iterating one bit per cycle; no new ops accepted
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic [3:0]       ccr
);

    logic [WIDTH-1:0] out_q;
    logic [3:0]       flags_q;
    logic [3:0]       ccr_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] core_res;
    logic [3:0]       core_flags;
    logic             issue;
    logic             retire;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .ccr_in    (ccr_q),
        .res       (core_res),
        .flags_nxt (core_flags)
    );

    assign issue  = in_valid && in_ready;
    assign retire = out_valid_q && out_ready;

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    alu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH:0]     psum_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [3:0]         mul_flags_d;

    // prod_q starts as {0, B}; each step adds A into the upper half when the
    // current multiplier LSB is set, then shifts the whole product right.
    always_comb begin
        psum_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d = {psum_d, prod_q[WIDTH-1:1]};
        mul_flags_d        = '0;
        mul_flags_d[CCR_C] = |prod_d[2*WIDTH-1:WIDTH];
        mul_flags_d[CCR_V] = |prod_d[2*WIDTH-1:WIDTH];
        mul_flags_d[CCR_N] = prod_d[WIDTH-1];
        mul_flags_d[CCR_Z] = ~|prod_d[WIDTH-1:0];
    end

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            out_q       <= '0;
            flags_q     <= '0;
            ccr_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue && (opcode == OP_MUL)) begin
                        state_q <= ST_MUL_RUN;
                        cnt_q   <= CNT_W'(WIDTH);
                        mcand_q <= A;
                        prod_q  <= {{WIDTH{1'b0}}, B};
                        if (retire) begin
                            out_valid_q <= 1'b0;
                        end
                    end else if (issue) begin
                        out_q       <= core_res;
                        flags_q     <= core_flags;
                        ccr_q       <= core_flags;
                        out_valid_q <= 1'b1;
                    end else if (retire) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_MUL_RUN: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    // terminal count: this step produces the final product
                    if (cnt_q == CNT_W'(1)) begin
                        out_q       <= prod_d[WIDTH-1:0];
                        flags_q     <= mul_flags_d;
                        ccr_q       <= mul_flags_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            flags_q     <= '0;
            ccr_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (issue) begin
                out_q       <= core_res;
                flags_q     <= core_flags;
                ccr_q       <= core_flags;
                out_valid_q <= 1'b1;
            end else if (retire) begin
                out_valid_q <= 1'b0;
            end
        end
    end
`endif

    assign out       = out_q;
    assign flags     = flags_q;
    assign ccr       = ccr_q;
    assign out_valid = out_valid_q;

endmodule
